// File: rtl/issue_scoreboard_pkg.sv
// Shared types and helpers for the issue controller: the execute-stage control
// bundle, the scoreboard bitmap type and the "does this write rd" predicate.
package issue_scoreboard_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ARCH_REGS  = 32;

  typedef logic [ARCH_REGS-1:0] scoreboard_t;

  // Decoded control bundle handed from decode to EX; iop marks a store when mem=1.
  typedef struct packed {
    logic                  load_upper_imm;
    logic                  uncond_branch;
    logic                  cond_branch;
    logic                  alu_imm;
    logic                  alu_reg;
    logic                  mem;
    logic                  iop;
    logic                  rs1_out;
    logic                  rs2_out;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [3:0]            alu_op;
  } control_ex_s;

  function automatic control_ex_s control_ex_s_default();
    control_ex_s c;
    c = '0;
    return c;
  endfunction

  // True when the instruction produces a register result (x0 is never tracked).
  function automatic logic writes_rd(input control_ex_s c);
    return (c.load_upper_imm | c.uncond_branch | c.alu_imm | c.alu_reg |
            (c.mem & ~c.iop)) & (c.rd != '0);
  endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Issue/EX handshake bundle for the issue controller.
//   i_valid/o_ready/i_control_signal/i_imm : decoder -> issue handshake
//   o_valid/i_ex_ready/o_control_signal/o_imm : issue -> EX handshake
// master: the surrounding pipeline (decoder + EX); slave: the issue controller.
interface issue_scoreboard_if;
  import issue_scoreboard_pkg::*;

  logic              i_valid;
  logic              o_ready;
  control_ex_s       i_control_signal;
  logic [XLEN-1:0]   i_imm;
  logic              o_valid;
  logic              i_ex_ready;
  control_ex_s       o_control_signal;
  logic [XLEN-1:0]   o_imm;

  modport master (
    output i_valid, i_control_signal, i_imm, i_ex_ready,
    input  o_ready, o_valid, o_control_signal, o_imm
  );

  modport slave (
    input  i_valid, i_control_signal, i_imm, i_ex_ready,
    output o_ready, o_valid, o_control_signal, o_imm
  );
endinterface

// File: rtl/issue_scoreboard_hazard_check.sv
// Combinational RAW/WAW hazard detection against the pending-write scoreboard.
//   scoreboard     : registered pending-write bitmap
//   wb_valid/wb_rd : same-cycle writeback, bypassed out of the scoreboard
//   control_signal : candidate instruction
//   hazard         : candidate must stall
//   sb_eff         : scoreboard with the writeback bit already cleared
module issue_hazard_check
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned NREGS = 32
) (
  input  logic [NREGS-1:0]      scoreboard,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  control_ex_s           control_signal,
  output logic                  hazard,
  output logic [NREGS-1:0]      sb_eff
);

  logic [NREGS-1:0] wb_mask;

  always_comb begin
    wb_mask = '0;
    if (wb_valid) wb_mask = NREGS'(1) << wb_rd;
    sb_eff = scoreboard & ~wb_mask;
    hazard = (control_signal.rs1_out & sb_eff[control_signal.rs1]) |
             (control_signal.rs2_out & sb_eff[control_signal.rs2]) |
             (writes_rd(control_signal) & sb_eff[control_signal.rd]);
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue controller: one-entry output register toward EX, pending-write
// scoreboard with writeback bypass, flush squash and a saturating counter of
// hazard-stall cycles.
//   i_clk, i_reset   : clock, synchronous active-high reset
//   bus (slave)      : decoder->issue and issue->EX handshakes
//   i_wb_valid/i_wb_rd : writeback retiring a register write
//   i_flush          : squash the held instruction
//   o_scoreboard     : pending-write bitmap (bit 0 always 0)
//   o_stall_cycles   : saturating hazard-stall cycle count
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  issue_scoreboard_if.slave     bus,
  input  logic                  i_wb_valid,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_flush,
  output logic [NREGS-1:0]      o_scoreboard,
  output logic [CNT_W-1:0]      o_stall_cycles
);

  logic              valid_q, valid_d;
  control_ex_s       ctrl_q, ctrl_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [NREGS-1:0]  sb_q, sb_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              hazard;
  logic [NREGS-1:0]  sb_eff;
  logic              slot_free;
  logic              accept;

  issue_hazard_check #(.NREGS(NREGS)) u_hazard (
    .scoreboard     (sb_q),
    .wb_valid       (i_wb_valid),
    .wb_rd          (i_wb_rd),
    .control_signal (bus.i_control_signal),
    .hazard         (hazard),
    .sb_eff         (sb_eff)
  );

  // Ready is combinational from the presented control bundle.
  assign slot_free   = ~valid_q | bus.i_ex_ready;
  assign bus.o_ready = ~hazard & slot_free & ~i_flush;
  assign accept      = bus.i_valid & bus.o_ready;

  // Next-state for output register, scoreboard and stall counter.
  always_comb begin
    valid_d     = valid_q;
    ctrl_d      = ctrl_q;
    imm_d       = imm_q;
    sb_d        = sb_eff;
    stall_cnt_d = stall_cnt_q;

    if (accept) begin
      valid_d = 1'b1;
      ctrl_d  = bus.i_control_signal;
      imm_d   = bus.i_imm;
    end else if (valid_q & (bus.i_ex_ready | i_flush)) begin
      // Consumed by EX or squashed; park the default bundle.
      valid_d = 1'b0;
      ctrl_d  = control_ex_s_default();
      imm_d   = '0;
    end

    // A squashed instruction never writes back, so release its rd.
    if (i_flush & valid_q & writes_rd(ctrl_q) & ~bus.i_ex_ready)
      sb_d[ctrl_q.rd] = 1'b0;

    if (accept & writes_rd(bus.i_control_signal))
      sb_d[bus.i_control_signal.rd] = 1'b1;

    sb_d[0] = 1'b0;

    if (bus.i_valid & hazard & ~i_flush & (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // State registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q     <= 1'b0;
      ctrl_q      <= control_ex_s_default();
      imm_q       <= '0;
      sb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      imm_q       <= imm_d;
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.o_valid          = valid_q;
  assign bus.o_control_signal = ctrl_q;
  assign bus.o_imm            = imm_q;
  assign o_scoreboard         = sb_q;
  assign o_stall_cycles       = stall_cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  localparam int unsigned NREGS = 32;
  localparam int unsigned CNT_W = 32;

  typedef struct packed {
    control_ex_s     ctrl;
    logic [XLEN-1:0] imm;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  flush;
  logic [NREGS-1:0]      sb;
  logic [CNT_W-1:0]      stalls;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  issue_scoreboard_if bus ();

  issue_scoreboard #(.NREGS(NREGS), .CNT_W(CNT_W)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .bus            (bus),
    .i_wb_valid     (wb_valid),
    .i_wb_rd        (wb_rd),
    .i_flush        (flush),
    .o_scoreboard   (sb),
    .o_stall_cycles (stalls)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic control_ex_s op_addi(input logic [4:0] rd, input logic [4:0] rs1);
    control_ex_s c = control_ex_s_default();
    c.alu_imm = 1'b1; c.rs1_out = 1'b1; c.rs1 = rs1; c.rd = rd; c.alu_op = 4'h1;
    return c;
  endfunction

  function automatic control_ex_s op_add(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    control_ex_s c = control_ex_s_default();
    c.alu_reg = 1'b1; c.rs1_out = 1'b1; c.rs2_out = 1'b1;
    c.rs1 = rs1; c.rs2 = rs2; c.rd = rd; c.alu_op = 4'h2;
    return c;
  endfunction

  function automatic control_ex_s op_lw(input logic [4:0] rd, input logic [4:0] rs1);
    control_ex_s c = control_ex_s_default();
    c.mem = 1'b1; c.rs1_out = 1'b1; c.rs1 = rs1; c.rd = rd;
    return c;
  endfunction

  function automatic control_ex_s op_lui(input logic [4:0] rd);
    control_ex_s c = control_ex_s_default();
    c.load_upper_imm = 1'b1; c.rd = rd;
    return c;
  endfunction

  // Store with a non-zero junk rd field: must still not touch the scoreboard.
  function automatic control_ex_s op_sw(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [4:0] junk_rd);
    control_ex_s c = control_ex_s_default();
    c.mem = 1'b1; c.iop = 1'b1; c.rs1_out = 1'b1; c.rs2_out = 1'b1;
    c.rs1 = rs1; c.rs2 = rs2; c.rd = junk_rd;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_valid          = 1'b0;
    bus.i_control_signal = control_ex_s_default();
    bus.i_imm            = '0;
    bus.i_ex_ready       = 1'b1;
    wb_valid             = 1'b0;
    wb_rd                = '0;
    flush                = 1'b0;
  endtask

  // Present an instruction and let o_ready settle.
  task automatic present(input control_ex_s c, input logic [XLEN-1:0] imm);
    bus.i_valid          = 1'b1;
    bus.i_control_signal = c;
    bus.i_imm            = imm;
    #1;
  endtask

  task automatic push_exp(input control_ex_s c, input logic [XLEN-1:0] imm);
    exp_t e;
    e.ctrl = c;
    e.imm  = imm;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    idle();
    present(op_addi(5'd1, 5'd0), 32'hdead);
    wb_valid = 1'b1; wb_rd = 5'd1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    n_tests++;
    if (bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid);
    end
    n_tests++;
    if (sb !== '0) begin
      n_fail++; $display("FAIL reset_sb: got %h expected 0", sb);
    end
    n_tests++;
    if (stalls !== '0) begin
      n_fail++; $display("FAIL reset_stalls: got %0d expected 0", stalls);
    end
    n_tests++;
    if (bus.o_imm !== '0 || bus.o_control_signal !== control_ex_s_default()) begin
      n_fail++; $display("FAIL reset_outreg: got imm %h ctrl %h expected 0", bus.o_imm,
                         bus.o_control_signal);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    present(op_addi(5'd1, 5'd0), 32'h11);
    n_tests++;
    if (bus.o_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready1: got %b expected 1", bus.o_ready);
    end
    push_exp(op_addi(5'd1, 5'd0), 32'h11);
    tick();
    e = exp_q.pop_front();
    n_tests++;
    if (bus.o_valid !== 1'b1 || bus.o_control_signal !== e.ctrl || bus.o_imm !== e.imm) begin
      n_fail++; $display("FAIL b2b_out1: got v=%b imm=%h expected v=1 imm=%h", bus.o_valid,
                         bus.o_imm, e.imm);
    end
    present(op_addi(5'd2, 5'd0), 32'h22);
    n_tests++;
    if (bus.o_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready2: got %b expected 1", bus.o_ready);
    end
    push_exp(op_addi(5'd2, 5'd0), 32'h22);
    tick();
    e = exp_q.pop_front();
    n_tests++;
    if (bus.o_valid !== 1'b1 || bus.o_control_signal !== e.ctrl || bus.o_imm !== e.imm) begin
      n_fail++; $display("FAIL b2b_out2: got v=%b imm=%h expected v=1 imm=%h", bus.o_valid,
                         bus.o_imm, e.imm);
    end
    n_tests++;
    if (sb !== 32'h6 || stalls !== '0) begin
      n_fail++; $display("FAIL b2b_sb: got sb=%h stalls=%0d expected sb=6 stalls=0", sb, stalls);
    end
    idle();
    tick();
    n_tests++;
    if (bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: got %b expected 0", bus.o_valid);
    end
  endtask

  task automatic test_raw();
    exp_t e;
    do_reset();
    present(op_addi(5'd5, 5'd0), 32'h5);
    push_exp(op_addi(5'd5, 5'd0), 32'h5);
    tick();
    void'(exp_q.pop_front());
    present(op_add(5'd6, 5'd5, 5'd7), 32'h66);
    n_tests++;
    if (bus.o_ready !== 1'b0) begin
      n_fail++; $display("FAIL raw_ready: got %b expected 0", bus.o_ready);
    end
    tick();
    n_tests++;
    if (stalls !== 32'd1) begin
      n_fail++; $display("FAIL raw_cnt1: got %0d expected 1", stalls);
    end
    tick();
    n_tests++;
    if (stalls !== 32'd2) begin
      n_fail++; $display("FAIL raw_cnt2: got %0d expected 2", stalls);
    end
    wb_valid = 1'b1; wb_rd = 5'd5;
    #1;
    n_tests++;
    if (bus.o_ready !== 1'b1) begin
      n_fail++; $display("FAIL raw_bypass_ready: got %b expected 1", bus.o_ready);
    end
    push_exp(op_add(5'd6, 5'd5, 5'd7), 32'h66);
    tick();
    idle();
    e = exp_q.pop_front();
    n_tests++;
    if (bus.o_valid !== 1'b1 || bus.o_control_signal !== e.ctrl || bus.o_imm !== e.imm) begin
      n_fail++; $display("FAIL raw_out: got v=%b imm=%h expected v=1 imm=%h", bus.o_valid,
                         bus.o_imm, e.imm);
    end
    n_tests++;
    if (sb !== 32'h40 || stalls !== 32'd2) begin
      n_fail++; $display("FAIL raw_sb: got sb=%h stalls=%0d expected sb=40 stalls=2", sb, stalls);
    end
  endtask

  task automatic test_waw();
    exp_t e;
    do_reset();
    present(op_lw(5'd3, 5'd1), 32'h30);
    push_exp(op_lw(5'd3, 5'd1), 32'h30);
    tick();
    void'(exp_q.pop_front());
    present(op_lui(5'd3), 32'h3000);
    n_tests++;
    if (bus.o_ready !== 1'b0) begin
      n_fail++; $display("FAIL waw_ready: got %b expected 0", bus.o_ready);
    end
    tick();
    n_tests++;
    if (stalls !== 32'd1) begin
      n_fail++; $display("FAIL waw_cnt: got %0d expected 1", stalls);
    end
    wb_valid = 1'b1; wb_rd = 5'd3;
    #1;
    push_exp(op_lui(5'd3), 32'h3000);
    tick();
    idle();
    e = exp_q.pop_front();
    n_tests++;
    if (bus.o_valid !== 1'b1 || bus.o_control_signal !== e.ctrl || bus.o_imm !== e.imm) begin
      n_fail++; $display("FAIL waw_out: got v=%b imm=%h expected v=1 imm=%h", bus.o_valid,
                         bus.o_imm, e.imm);
    end
    n_tests++;
    if (sb !== 32'h8) begin
      n_fail++; $display("FAIL waw_sb: got %h expected 8", sb);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    do_reset();
    present(op_addi(5'd4, 5'd0), 32'h44);
    push_exp(op_addi(5'd4, 5'd0), 32'h44);
    tick();
    e = exp_q.pop_front();
    bus.i_ex_ready = 1'b0;
    present(op_addi(5'd7, 5'd0), 32'h77);
    n_tests++;
    if (bus.o_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_ready: got %b expected 0", bus.o_ready);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (bus.o_valid !== 1'b1 || bus.o_imm !== e.imm || bus.o_control_signal !== e.ctrl ||
          stalls !== '0) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b imm=%h stalls=%0d expected v=1 imm=%h stalls=0",
                           i, bus.o_valid, bus.o_imm, stalls, e.imm);
      end
    end
    bus.i_ex_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.o_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got %b expected 1", bus.o_ready);
    end
    push_exp(op_addi(5'd7, 5'd0), 32'h77);
    tick();
    idle();
    e = exp_q.pop_front();
    n_tests++;
    if (bus.o_valid !== 1'b1 || bus.o_imm !== e.imm || sb !== 32'h90) begin
      n_fail++; $display("FAIL bp_out: got v=%b imm=%h sb=%h expected v=1 imm=%h sb=90",
                         bus.o_valid, bus.o_imm, sb, e.imm);
    end
  endtask

  task automatic test_flush();
    do_reset();
    present(op_addi(5'd9, 5'd0), 32'h99);
    push_exp(op_addi(5'd9, 5'd0), 32'h99);
    tick();
    void'(exp_q.pop_front());
    bus.i_ex_ready = 1'b0;
    flush          = 1'b1;
    present(op_addi(5'd10, 5'd0), 32'haa);
    n_tests++;
    if (bus.o_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_ready: got %b expected 0", bus.o_ready);
    end
    tick();
    idle();
    n_tests++;
    if (bus.o_valid !== 1'b0 || sb !== '0 || stalls !== '0) begin
      n_fail++; $display("FAIL flush_drop: got v=%b sb=%h stalls=%0d expected v=0 sb=0 stalls=0",
                         bus.o_valid, sb, stalls);
    end
    tick();
    n_tests++;
    if (bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_noaccept: got %b expected 0", bus.o_valid);
    end
    // Flush coinciding with EX consume: the instruction already left, bit stays.
    present(op_addi(5'd9, 5'd0), 32'h99);
    push_exp(op_addi(5'd9, 5'd0), 32'h99);
    tick();
    void'(exp_q.pop_front());
    bus.i_valid = 1'b0;
    flush       = 1'b1;
    tick();
    idle();
    n_tests++;
    if (bus.o_valid !== 1'b0 || sb !== 32'h200) begin
      n_fail++; $display("FAIL flush_consumed: got v=%b sb=%h expected v=0 sb=200",
                         bus.o_valid, sb);
    end
  endtask

  task automatic test_no_write();
    exp_t e;
    do_reset();
    present(op_addi(5'd0, 5'd0), 32'h1);
    push_exp(op_addi(5'd0, 5'd0), 32'h1);
    tick();
    e = exp_q.pop_front();
    n_tests++;
    if (bus.o_valid !== 1'b1 || bus.o_imm !== e.imm || sb !== '0) begin
      n_fail++; $display("FAIL rd0_sb: got v=%b sb=%h expected v=1 sb=0", bus.o_valid, sb);
    end
    present(op_sw(5'd1, 5'd2, 5'd5), 32'h8);
    push_exp(op_sw(5'd1, 5'd2, 5'd5), 32'h8);
    tick();
    e = exp_q.pop_front();
    n_tests++;
    if (bus.o_control_signal !== e.ctrl || sb !== '0) begin
      n_fail++; $display("FAIL store_sb: got sb=%h expected 0", sb);
    end
    bus.i_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd0;
    tick();
    wb_rd = 5'd12;
    tick();
    idle();
    n_tests++;
    if (sb !== '0 || bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL stray_wb: got sb=%h v=%b expected sb=0 v=0", sb, bus.o_valid);
    end
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] sat;
    sat = {CNT_W{1'b1}};
    do_reset();
    present(op_addi(5'd5, 5'd0), 32'h5);
    push_exp(op_addi(5'd5, 5'd0), 32'h5);
    tick();
    void'(exp_q.pop_front());
    bus.i_valid = 1'b0;
    force dut.stall_cnt_q = sat - CNT_W'(2);
    #1;
    release dut.stall_cnt_q;
    present(op_add(5'd6, 5'd5, 5'd0), 32'h0);
    tick();
    n_tests++;
    if (stalls !== sat - CNT_W'(1)) begin
      n_fail++; $display("FAIL sat_step: got %h expected %h", stalls, sat - CNT_W'(1));
    end
    tick();
    n_tests++;
    if (stalls !== sat) begin
      n_fail++; $display("FAIL sat_reach: got %h expected %h", stalls, sat);
    end
    tick();
    tick();
    idle();
    n_tests++;
    if (stalls !== sat) begin
      n_fail++; $display("FAIL sat_hold: got %h expected %h", stalls, sat);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    present(op_addi(5'd5, 5'd0), 32'h5);
    push_exp(op_addi(5'd5, 5'd0), 32'h5);
    tick();
    void'(exp_q.pop_front());
    bus.i_ex_ready = 1'b0;
    present(op_add(5'd6, 5'd5, 5'd0), 32'h6);
    tick();
    n_tests++;
    if (stalls !== 32'd1 || bus.o_valid !== 1'b1 || sb !== 32'h20) begin
      n_fail++; $display("FAIL midrst_pre: got stalls=%0d v=%b sb=%h expected 1 1 20",
                         stalls, bus.o_valid, sb);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    n_tests++;
    if (bus.o_valid !== 1'b0 || sb !== '0 || stalls !== '0 || bus.o_imm !== '0) begin
      n_fail++; $display("FAIL midrst_clear: got v=%b sb=%h stalls=%0d imm=%h expected all 0",
                         bus.o_valid, sb, stalls, bus.o_imm);
    end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_back_to_back();
    test_raw();
    test_waw();
    test_backpressure();
    test_flush();
    test_no_write();
    test_saturation();
    test_reset_mid_stall();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_left: got %0d entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
Issue controller between decoder_logic and the execute stage. It holds one decoded instruction (control_ex_s plus immediate) in an output register and tracks in-flight destination registers in a 1-bit-per-register scoreboard. It stalls issue on RAW/WAW hazards and releases entries on writeback. A flush port squashes the held instruction, and a saturating counter reports hazard-stall cycles.

Parameters:
NREGS, 32, number of architectural registers; scoreboard width; x0 is never tracked.
CNT_W, 32, width of the stall performance counter.

Ports:
i_clk  input  1  clock, all state updates on rising edge.
i_reset  input  1  synchronous, active-high reset.
i_valid  input  1  decoded instruction present on i_control_signal/i_imm.
o_ready  output  1  issue controller accepts the instruction this cycle.
i_control_signal  input  control_ex_s  decoded control bundle from decoder_logic.
i_imm  input  XLEN  signed immediate from decoder_logic.
o_valid  output  1  output register holds an instruction for EX.
i_ex_ready  input  1  EX consumes the output register this cycle.
o_control_signal  output  control_ex_s  registered control bundle to EX.
o_imm  output  XLEN  registered immediate to EX.
i_wb_valid  input  1  writeback retires a register write this cycle.
i_wb_rd  input  5  destination register of the writeback.
i_flush  input  1  squash the held instruction (branch redirect).
o_scoreboard  output  NREGS  pending-write bitmap, bit 0 always 0.
o_stall_cycles  output  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset, synchronous on i_reset=1: o_valid=0, o_control_signal=control_ex_s_default(), o_imm=0, scoreboard=0, o_stall_cycles=0. Reset overrides all other inputs in the same cycle.
- writes_rd(c) = load_upper_imm | uncond_branch | alu_imm | alu_reg | (mem & ~iop), and rd != 0.
- Effective scoreboard: sb_eff = scoreboard & ~(i_wb_valid ? onehot(i_wb_rd) : 0). This gives a same-cycle writeback bypass.
- hazard: any of the following against sb_eff:
  - rs1_out & sb_eff[rs1]
  - rs2_out & sb_eff[rs2]
  - writes_rd & sb_eff[rd] (WAW)
- slot_free = ~o_valid | i_ex_ready.
- o_ready = ~hazard & slot_free & ~i_flush. This is combinational from i_control_signal, so the upstream stage must not derive i_valid from o_ready.
- accept = i_valid & o_ready. Next cycle: o_valid=1, output register loads the inputs, and scoreboard[rd] is set if writes_rd.
- Else if i_ex_ready & o_valid: o_valid=0. The output register contents are don't-care, but the reset-default bundle is held.
- Scoreboard update, in this order of precedence:
  - Clear the i_wb_rd bit when i_wb_valid.
  - Clear the held instruction's rd bit on i_flush & o_valid & writes_rd(o_control_signal) & ~i_ex_ready.
  - Set for accept; set wins over a same-cycle clear of the same register.
- i_flush: the held instruction is dropped (o_valid=0 next cycle) unless i_ex_ready is high in that same cycle, in which case it counts as consumed and its bit stays. No accept occurs during a flush cycle.
- Writeback to a register whose bit is 0, or i_wb_rd=0: no effect, no error.
- o_stall_cycles increments when i_valid & hazard & ~i_flush, and saturates at all-ones without wrapping. Slot-busy stalls (i_ex_ready=0) are not counted.
- Latency: an accepted instruction appears on the output register the next cycle. Throughput is one per cycle when there are no hazards.
- An instruction with no register writes (cond_branch, store) never sets the scoreboard.

Decomposition:
- rapid_pkg gains:
  - typedef scoreboard_t (logic [NREGS-1:0]).
  - function writes_rd(control_ex_s).
  - localparam REG_ADDR_W=5.
- Sub-module issue_hazard_check (combinational): inputs scoreboard, wb bypass, control bundle; outputs hazard and sb_eff. The top level holds the output register, scoreboard register, counter and flush logic.

Test Plan:
- Back-to-back independent ops: ADDI x1 then ADDI x2, i_ex_ready=1, no wb → both accepted on consecutive cycles, o_scoreboard=0x6, o_stall_cycles=0.
- RAW stall: ADDI x5 issued, then ADD x6,x5,x7 presented → o_ready=0 and o_stall_cycles increments each cycle. Assert i_wb_valid with i_wb_rd=5 → ADD accepted that same cycle, o_scoreboard=0x40.
- WAW: LW x3 pending, then LUI x3 presented → stall. wb rd=3 → LUI accepted, bit 3 remains set.
- Backpressure: i_ex_ready=0 with o_valid=1 → o_ready=0, output register and o_imm stable, counter unchanged.
- Flush: ADDI x9 held, i_ex_ready=0, i_flush=1 → o_valid=0 next cycle and bit 9 cleared. A concurrent i_valid is not accepted.
- Edge cases:
  - rd=0 instructions never set bit 0.
  - Counter preloaded near saturation by force holds at 2^CNT_W-1.
  - i_reset asserted mid-stall → all outputs and scoreboard cleared next edge.
